// File: rtl/grid_frame_sync.sv
// Frame-synchronous grid latch, welcome/arm/play sequencer and new-tile flash tracker.
// Optional flash tracking is built only when GRID_FRAME_SYNC_FLASH_EN is defined.
module grid_frame_sync #(
  parameter int GRID_N       = 4,
  parameter int TILE_W       = 4,
  parameter int FLASH_FRAMES = 25,
  parameter int CNT_W        = 5,
  parameter int IDX_W        = $clog2(GRID_N*GRID_N)
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              vsync,
  input  logic [GRID_N*GRID_N*TILE_W-1:0]   game_grid,
  input  logic [GRID_N*GRID_N*TILE_W-1:0]   welcome_grid,
  input  logic                              btn_any,
  input  logic                              restart,
  input  logic                              tile_added_valid,
  input  logic [IDX_W-1:0]                  tile_added_idx,
  output logic [GRID_N*GRID_N*TILE_W-1:0]   grid_out,
  output logic [GRID_N*GRID_N-1:0]          new_tiles,
  output logic [2:0]                        flash_phase,
  output logic                              frame_strobe,
  output logic                              show_welcome,
  output logic                              move_enable
);

  localparam int C  = GRID_N*GRID_N;
  localparam int GW = C*TILE_W;

  typedef enum logic [1:0] {
    S_WELCOME = 2'd0,
    S_ARMED   = 2'd1,
    S_PLAYING = 2'd2
  } state_t;

  logic          vsync_q;
  state_t        state_q, state_d;
  logic [GW-1:0] grid_q, grid_d;

  assign frame_strobe = vsync & ~vsync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q <= 1'b1;
      state_q <= S_WELCOME;
      grid_q  <= '0;
    end else begin
      vsync_q <= vsync;
      state_q <= state_d;
      grid_q  <= grid_d;
    end
  end

  // ARMED waits for the dismissing press to be released before enabling moves.
  always_comb begin
    state_d = state_q;
    grid_d  = grid_q;
    case (state_q)
      S_WELCOME: begin
        if (frame_strobe) begin
          grid_d = welcome_grid;
          if (btn_any) state_d = S_ARMED;
        end
      end
      S_ARMED: begin
        if (frame_strobe) begin
          grid_d = game_grid;
          if (!btn_any) state_d = S_PLAYING;
        end
      end
      S_PLAYING: begin
        if (frame_strobe) grid_d = game_grid;
      end
      default: state_d = S_WELCOME;
    endcase
    if (restart) state_d = S_WELCOME;
  end

  assign grid_out     = grid_q;
  assign show_welcome = (state_q == S_WELCOME);
  assign move_enable  = (state_q == S_PLAYING);

`ifdef GRID_FRAME_SYNC_FLASH_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [C-1:0]     mask_q, mask_d;
  logic             add_ok;
  logic [C-1:0]     add_bit;

  assign add_ok  = tile_added_valid && ({1'b0, tile_added_idx} < (IDX_W+1)'(C));
  assign add_bit = C'(1) << tile_added_idx;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      mask_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      mask_q <= mask_d;
    end
  end

  // A spawn outranks the frame tick so a fresh tile never misses its first frame.
  always_comb begin
    cnt_d  = cnt_q;
    mask_d = mask_q;
    if (frame_strobe) begin
      if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
      else             mask_d = '0;
    end
    if (add_ok) begin
      cnt_d  = CNT_W'(FLASH_FRAMES);
      mask_d = mask_q | add_bit;
    end
    if (restart) begin
      cnt_d  = '0;
      mask_d = '0;
    end
  end

  assign new_tiles   = mask_q;
  assign flash_phase = cnt_q[3:1];
`else
  logic unused_flash_in;
  assign unused_flash_in = ^{tile_added_valid, tile_added_idx};
  assign new_tiles   = '0;
  assign flash_phase = '0;
`endif

endmodule

// File: tb/tb_grid_frame_sync.sv
// Directed bench for grid_frame_sync: reset, welcome latch, arming, flash window, restart.
`timescale 1ns/1ps
module tb_grid_frame_sync;

`ifdef GRID_FRAME_SYNC_FLASH_EN
  localparam bit FLASH = 1'b1;
`else
  localparam bit FLASH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        vsync;
  logic [63:0] game_grid;
  logic [63:0] welcome_grid;
  logic        btn_any;
  logic        restart;
  logic        tile_added_valid;
  logic [4:0]  tile_added_idx;
  logic [63:0] grid_out;
  logic [15:0] new_tiles;
  logic [2:0]  flash_phase;
  logic        frame_strobe;
  logic        show_welcome;
  logic        move_enable;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  // IDX_W widened to 5 so out-of-range spawn cells (>= 16) can be driven.
  grid_frame_sync #(.GRID_N(4), .TILE_W(4), .FLASH_FRAMES(25), .CNT_W(5), .IDX_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync),
    .game_grid(game_grid), .welcome_grid(welcome_grid),
    .btn_any(btn_any), .restart(restart),
    .tile_added_valid(tile_added_valid), .tile_added_idx(tile_added_idx),
    .grid_out(grid_out), .new_tiles(new_tiles), .flash_phase(flash_phase),
    .frame_strobe(frame_strobe), .show_welcome(show_welcome), .move_enable(move_enable)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame: vsync rising edge sampled, then vsync low again.
  task automatic frame();
    vsync = 1'b1;
    tick();
    vsync = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; vsync = 1'b1; btn_any = 1'b0; restart = 1'b0;
    tile_added_valid = 1'b0; tile_added_idx = '0;
    game_grid = 64'h0; welcome_grid = 64'h0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    vec_cnt++;
    if (grid_out !== 64'h0) begin err_cnt++; $display("FAIL reset_grid got %h want 0", grid_out); end
    vec_cnt++;
    if (show_welcome !== 1'b1 || move_enable !== 1'b0) begin
      err_cnt++; $display("FAIL reset_state got sw=%b me=%b want sw=1 me=0", show_welcome, move_enable);
    end
    vec_cnt++;
    if (new_tiles !== 16'h0 || flash_phase !== 3'd0) begin
      err_cnt++; $display("FAIL reset_flash got nt=%h ph=%0d want 0/0", new_tiles, flash_phase);
    end
    for (int i = 0; i < 10; i++) begin
      vec_cnt++;
      if (frame_strobe !== 1'b0) begin err_cnt++; $display("FAIL vsync_held_strobe cycle %0d got %b want 0", i, frame_strobe); end
      tick();
    end
    vec_cnt++;
    if (grid_out !== 64'h0) begin err_cnt++; $display("FAIL held_grid got %h want 0", grid_out); end
    vsync = 1'b0;
    tick();
  endtask

  task automatic test_welcome();
    welcome_grid = 64'h1234_5678_9ABC_DEF0;
    game_grid    = 64'hFEDC_BA98_7654_3210;
    btn_any      = 1'b0;
    vsync = 1'b1;
    #1;
    vec_cnt++;
    if (frame_strobe !== 1'b1) begin err_cnt++; $display("FAIL strobe_rise got %b want 1", frame_strobe); end
    tick();
    vec_cnt++;
    if (frame_strobe !== 1'b0) begin err_cnt++; $display("FAIL strobe_width got %b want 0", frame_strobe); end
    vec_cnt++;
    if (grid_out !== 64'h1234_5678_9ABC_DEF0) begin err_cnt++; $display("FAIL welcome_grid got %h want 123456789abcdef0", grid_out); end
    vec_cnt++;
    if (show_welcome !== 1'b1) begin err_cnt++; $display("FAIL welcome_stay got %b want 1", show_welcome); end
    welcome_grid = 64'h1111_2222_3333_4444;
    vsync = 1'b0;
    tick(); tick();
    vec_cnt++;
    if (grid_out !== 64'h1234_5678_9ABC_DEF0) begin err_cnt++; $display("FAIL midframe_hold got %h want 123456789abcdef0", grid_out); end
  endtask

  task automatic test_arm();
    welcome_grid = 64'hAAAA_0000_AAAA_0000;
    game_grid    = 64'h0123_4567_0123_4567;
    btn_any = 1'b1;
    frame();
    vec_cnt++;
    if (show_welcome !== 1'b0 || move_enable !== 1'b0) begin
      err_cnt++; $display("FAIL arm_s1_state got sw=%b me=%b want 0/0", show_welcome, move_enable);
    end
    vec_cnt++;
    if (grid_out !== 64'hAAAA_0000_AAAA_0000) begin err_cnt++; $display("FAIL arm_s1_grid got %h want aaaa0000aaaa0000", grid_out); end
    for (int s = 2; s <= 3; s++) begin
      frame();
      vec_cnt++;
      if (move_enable !== 1'b0 || show_welcome !== 1'b0) begin
        err_cnt++; $display("FAIL arm_hold_s%0d got sw=%b me=%b want 0/0", s, show_welcome, move_enable);
      end
      vec_cnt++;
      if (grid_out !== 64'h0123_4567_0123_4567) begin err_cnt++; $display("FAIL arm_grid_s%0d got %h want 0123456701234567", s, grid_out); end
    end
    btn_any = 1'b0;
    frame();
    vec_cnt++;
    if (move_enable !== 1'b1 || show_welcome !== 1'b0) begin
      err_cnt++; $display("FAIL play_enter got sw=%b me=%b want 0/1", show_welcome, move_enable);
    end
  endtask

  task automatic test_flash();
    tile_added_valid = 1'b1; tile_added_idx = 5'd0;
    tick();
    tile_added_valid = 1'b0;
    vec_cnt++;
    if (new_tiles !== (FLASH ? 16'h0001 : 16'h0) || flash_phase !== (FLASH ? 3'd4 : 3'd0)) begin
      err_cnt++; $display("FAIL add_idx0 got nt=%h ph=%0d want %h/%0d", new_tiles, flash_phase, FLASH ? 16'h1 : 16'h0, FLASH ? 4 : 0);
    end
    for (int s = 1; s <= 25; s++) begin
      frame();
      if (s == 10) begin
        vec_cnt++;
        if (flash_phase !== (FLASH ? 3'd7 : 3'd0)) begin err_cnt++; $display("FAIL phase_cnt15 got %0d want %0d", flash_phase, FLASH ? 7 : 0); end
      end
    end
    vec_cnt++;
    if (new_tiles !== (FLASH ? 16'h0001 : 16'h0) || flash_phase !== 3'd0) begin
      err_cnt++; $display("FAIL after25 got nt=%h ph=%0d want %h/0", new_tiles, flash_phase, FLASH ? 16'h1 : 16'h0);
    end
    // Spawn on the very strobe that would otherwise clear the mask.
    vsync = 1'b1; tile_added_valid = 1'b1; tile_added_idx = 5'd5;
    tick();
    vsync = 1'b0; tile_added_valid = 1'b0;
    tick();
    vec_cnt++;
    if (new_tiles !== (FLASH ? 16'h0021 : 16'h0) || flash_phase !== (FLASH ? 3'd4 : 3'd0)) begin
      err_cnt++; $display("FAIL add_on_strobe got nt=%h ph=%0d want %h/%0d", new_tiles, flash_phase, FLASH ? 16'h21 : 16'h0, FLASH ? 4 : 0);
    end
    frame(); frame();
    tile_added_valid = 1'b1; tile_added_idx = 5'd16;
    tick();
    tile_added_valid = 1'b0;
    vec_cnt++;
    if (new_tiles !== (FLASH ? 16'h0021 : 16'h0) || flash_phase !== (FLASH ? 3'd3 : 3'd0)) begin
      err_cnt++; $display("FAIL idx16_ignored got nt=%h ph=%0d want %h/%0d", new_tiles, flash_phase, FLASH ? 16'h21 : 16'h0, FLASH ? 3 : 0);
    end
    for (int s = 1; s <= 23; s++) frame();
    vec_cnt++;
    if (new_tiles !== (FLASH ? 16'h0021 : 16'h0)) begin err_cnt++; $display("FAIL before_clear got %h want %h", new_tiles, FLASH ? 16'h21 : 16'h0); end
    frame();
    vec_cnt++;
    if (new_tiles !== 16'h0 || flash_phase !== 3'd0) begin err_cnt++; $display("FAIL window_clear got nt=%h ph=%0d want 0/0", new_tiles, flash_phase); end
  endtask

  task automatic test_restart();
    tile_added_valid = 1'b1; tile_added_idx = 5'd3;
    tick();
    tile_added_valid = 1'b0;
    frame();
    vec_cnt++;
    if (new_tiles !== (FLASH ? 16'h0008 : 16'h0) || flash_phase !== (FLASH ? 3'd4 : 3'd0)) begin
      err_cnt++; $display("FAIL pre_restart got nt=%h ph=%0d want %h/%0d", new_tiles, flash_phase, FLASH ? 16'h8 : 16'h0, FLASH ? 4 : 0);
    end
    game_grid = 64'hCAFE_F00D_DEAD_BEEF;
    vsync = 1'b1; restart = 1'b1;
    tick();
    restart = 1'b0; vsync = 1'b0;
    vec_cnt++;
    if (show_welcome !== 1'b1 || move_enable !== 1'b0) begin
      err_cnt++; $display("FAIL restart_state got sw=%b me=%b want 1/0", show_welcome, move_enable);
    end
    vec_cnt++;
    if (new_tiles !== 16'h0 || flash_phase !== 3'd0) begin err_cnt++; $display("FAIL restart_flash got nt=%h ph=%0d want 0/0", new_tiles, flash_phase); end
    vec_cnt++;
    if (grid_out !== 64'hCAFE_F00D_DEAD_BEEF) begin err_cnt++; $display("FAIL restart_grid got %h want cafef00ddeadbeef", grid_out); end
    tick();
  endtask

  task automatic test_reset_mid();
    tile_added_valid = 1'b1; tile_added_idx = 5'd9;
    btn_any = 1'b1; frame();
    tile_added_valid = 1'b0;
    btn_any = 1'b0;
    vsync = 1'b1; rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    vec_cnt++;
    if (grid_out !== 64'h0 || new_tiles !== 16'h0 || flash_phase !== 3'd0 || show_welcome !== 1'b1 || frame_strobe !== 1'b0) begin
      err_cnt++; $display("FAIL reset_mid got g=%h nt=%h ph=%0d sw=%b fs=%b want 0/0/0/1/0", grid_out, new_tiles, flash_phase, show_welcome, frame_strobe);
    end
    vsync = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_welcome();
    test_arm();
    test_flash();
    test_restart();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
